stb_channel_arbiter: RTL and testbench

//  Shares one single-bit clock-crossing strobe channel among NREQ event

---
 rtl/stb_channel_arbiter.sv | 170 +++++++++++++++++
 tb/tb_stb_channel_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stb_channel_arbiter.sv
`timescale 1ns/1ps
// stb_channel_arbiter
//
// Shares one single-bit clock-crossing strobe channel among NREQ event
// sources. Each source's events land in a sticky pending flag; pending
// sources are granted round-robin, one strobe at a time. After every strobe
// the arbiter sits in HOLD for at least HOLDOFF cycles. When USE_ACK is set,
// it also waits for the crossing's acknowledge before it can issue again.
//
// Handshake: o_stb is a one-cycle launch pulse with no backpressure. o_id is
// valid in the o_stb cycle and holds until the next grant. Flow control comes
// entirely from the HOLD pacing: the HOLDOFF timer, plus i_ack when USE_ACK=1.
// i_ack is a one-cycle pulse. It only counts while in HOLD, and not in the
// o_stb cycle itself, so an ack left over from the previous strobe cannot
// release the current one.
//
// FSM state is visible on o_busy, which is exactly (state == HOLD).

module stb_channel_arbiter #(
  parameter int NREQ    = 4,
  parameter int HOLDOFF = 12,
  parameter bit USE_ACK = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic [NREQ-1:0]         i_req,
  input  logic                    i_ack,
  output logic                    o_stb,
  output logic [$clog2(NREQ)-1:0] o_id,
  output logic [NREQ-1:0]         o_pending,
  output logic [NREQ-1:0]         o_overflow,
  output logic                    o_busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(HOLDOFF);

  localparam logic [CW-1:0]  CNT_RELOAD = CW'(HOLDOFF - 1);
  localparam logic [IDW-1:0] LAST_RST   = IDW'(NREQ - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // Registered state
  logic [0:0]      state_q,    state_d;
  logic [CW-1:0]   cnt_q,      cnt_d;
  logic            ack_seen_q, ack_seen_d;
  logic [IDW-1:0]  last_q,     last_d;
  logic [IDW-1:0]  id_q,       id_d;
  logic            stb_q,      stb_d;
  logic [NREQ-1:0] pending_q,  pending_d;
  logic [NREQ-1:0] ovf_q,      ovf_d;

  // Combinational helpers
  logic            win_found;
  logic [IDW-1:0]  win_idx;
  logic            any_pend;
  logic            hold_release;
  logic            grant;
  logic [NREQ-1:0] grant_mask;

  // Round-robin search: first pending index starting at last+1, wrapping.
  always_comb begin
    int             cand;
    logic [IDW-1:0] cand_idx;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand     = (int'(last_q) + i) % NREQ;
      cand_idx = IDW'(cand);
      if (!win_found && pending_q[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Grant decision: a grant from IDLE, or back-to-back from HOLD on release.
  always_comb begin
    any_pend     = |pending_q;
    hold_release = (cnt_q == '0) && (ack_seen_q || !USE_ACK);
    grant        = any_pend && win_found &&
                   ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && hold_release));
    grant_mask   = grant ? (NREQ'(1) << win_idx) : '0;
  end

  // Pending/overflow bookkeeping. A new event arriving in the same cycle as
  // its source's grant is re-queued rather than flagged as an overflow.
  always_comb begin
    pending_d = (pending_q & ~grant_mask) | i_req;
    ovf_d     = i_req & pending_q & ~grant_mask;
  end

  // Strobe, identity and round-robin pointer updates.
  always_comb begin
    stb_d  = grant;
    id_d   = grant ? win_idx : id_q;
    last_d = grant ? win_idx : last_q;
  end

  // Pacing FSM: the IDLE/HOLD transitions, the hold-off counter and the
  // ack latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ack_seen_d = ack_seen_q;
    case (state_q)
      ST_IDLE: begin
        // Acks arriving while idle belong to nothing outstanding.
        ack_seen_d = 1'b0;
        if (grant) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_RELOAD;
        end
      end
      ST_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
        if (i_ack && !stb_q) begin
          ack_seen_d = 1'b1;
        end
        if (hold_release) begin
          ack_seen_d = 1'b0;
          if (grant) begin
            cnt_d = CNT_RELOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        ack_seen_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ack_seen_q <= 1'b0;
      last_q     <= LAST_RST;
      id_q       <= '0;
      stb_q      <= 1'b0;
      pending_q  <= '0;
      ovf_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ack_seen_q <= ack_seen_d;
      last_q     <= last_d;
      id_q       <= id_d;
      stb_q      <= stb_d;
      pending_q  <= pending_d;
      ovf_q      <= ovf_d;
    end
  end

  assign o_stb      = stb_q;
  assign o_id       = id_q;
  assign o_pending  = pending_q;
  assign o_overflow = ovf_q;
  assign o_busy     = (state_q == ST_HOLD);

endmodule

// File: tb/tb_stb_channel_arbiter.sv
`timescale 1ns/1ps
// Bench for stb_channel_arbiter. It runs two instances side by side on one
// clock: dut0 uses the timer only (USE_ACK=0) and dut1 also waits for the
// ack (USE_ACK=1). Each expected strobe is queued with its cycle and id.
// Monitors pop the queue on every o_stb.

module tb_stb_channel_arbiter;

  localparam int NREQ    = 4;
  localparam int HOLDOFF = 12;
  localparam int IDW     = 2;
  localparam int W       = 40;

  // Clock/reset
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT signals
  logic [NREQ-1:0] req0, req1;
  logic            ack0, ack1;
  logic            stb0, stb1;
  logic [IDW-1:0]  id0, id1;
  logic [NREQ-1:0] pend0, pend1;
  logic [NREQ-1:0] ovf0, ovf1;
  logic            busy0, busy1;

  stb_channel_arbiter #(.NREQ(NREQ), .HOLDOFF(HOLDOFF), .USE_ACK(1'b0)) dut0 (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_req      (req0),
    .i_ack      (ack0),
    .o_stb      (stb0),
    .o_id       (id0),
    .o_pending  (pend0),
    .o_overflow (ovf0),
    .o_busy     (busy0)
  );

  stb_channel_arbiter #(.NREQ(NREQ), .HOLDOFF(HOLDOFF), .USE_ACK(1'b1)) dut1 (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_req      (req1),
    .i_ack      (ack1),
    .o_stb      (stb1),
    .o_id       (id1),
    .o_pending  (pend1),
    .o_overflow (ovf1),
    .o_busy     (busy1)
  );

  // Scoreboard: entries are {cycle[31:0], id[7:0]}
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] e0, e1;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push0(input int c, input int id);
    exp_q0.push_back({32'(c), 8'(id)});
  endtask

  task automatic push1(input int c, input int id);
    exp_q1.push_back({32'(c), 8'(id)});
  endtask

  // Monitor for dut0 strobes
  always @(negedge clk) begin
    if (stb0 === 1'b1) begin
      if (exp_q0.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL stb0_unexpected: got strobe id %0d at cycle %0d, required none", id0, cyc);
      end else begin
        e0 = exp_q0.pop_front();
        check("stb0_cycle", 32'(cyc), e0[39:8]);
        check("stb0_id", 32'(id0), 32'(e0[7:0]));
      end
    end
  end

  // Monitor for dut1 strobes
  always @(negedge clk) begin
    if (stb1 === 1'b1) begin
      if (exp_q1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL stb1_unexpected: got strobe id %0d at cycle %0d, required none", id1, cyc);
      end else begin
        e1 = exp_q1.pop_front();
        check("stb1_cycle", 32'(cyc), e1[39:8]);
        check("stb1_id", 32'(id1), 32'(e1[7:0]));
      end
    end
  end

  // Driver helpers: goto lands just after the posedge that starts cycle c.
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_neg(input int c);
    goto(c);
    @(negedge clk);
  endtask

  // Stimulus
  initial begin
    rst_n = 1'b0;
    req0  = '0;
    req1  = '0;
    ack0  = 1'b0;
    ack1  = 1'b0;
    goto(3);
    rst_n = 1'b1;
    at_neg(3);
    check("rst_stb0", 32'(stb0), 0);
    check("rst_id0", 32'(id0), 0);
    check("rst_pend0", 32'(pend0), 0);
    check("rst_ovf0", 32'(ovf0), 0);
    check("rst_busy0", 32'(busy0), 0);
    check("rst_busy1", 32'(busy1), 0);

    // Test 1: single event, latency 2, second strobe HOLDOFF later
    goto(10); req0 = 4'b0001; push0(12, 0);
    goto(11); req0 = '0;
    at_neg(11);
    check("t1_pend", 32'(pend0), 4'b0001);
    goto(13); req0 = 4'b0010; push0(24, 1);
    goto(14); req0 = '0;
    at_neg(14);
    check("t1_pend2", 32'(pend0), 4'b0010);
    at_neg(30);
    check("t1_busy_hold", 32'(busy0), 1);
    at_neg(35);
    check("t1_busy_last", 32'(busy0), 1);
    at_neg(36);
    check("t1_busy_idle", 32'(busy0), 0);

    // Reset so the round-robin pointer restarts at NREQ-1
    goto(40); rst_n = 1'b0;
    goto(42); rst_n = 1'b1;
    at_neg(42);
    check("rst2_id0", 32'(id0), 0);
    check("rst2_busy0", 32'(busy0), 0);

    // Test 2: all four sources in one cycle drain 0,1,2,3 at 12-cycle spacing
    goto(45); req0 = 4'b1111;
    push0(47, 0); push0(59, 1); push0(71, 2); push0(83, 3);
    goto(46); req0 = '0;
    at_neg(46);
    check("t2_pend_all", 32'(pend0), 4'b1111);
    at_neg(48);
    check("t2_pend_after0", 32'(pend0), 4'b1110);
    at_neg(94);
    check("t2_busy_last", 32'(busy0), 1);
    at_neg(95);
    check("t2_busy_idle", 32'(busy0), 0);

    // Test 3: source 2 overflows once, then re-queues during its grant cycle
    goto(100); req0 = 4'b0001; push0(102, 0);
    goto(101); req0 = '0;
    goto(103); req0 = 4'b0100;
    goto(104); req0 = '0;
    goto(105); req0 = 4'b0100;
    goto(106); req0 = '0;
    at_neg(106);
    check("t3_ovf_pulse", 32'(ovf0), 4'b0100);
    at_neg(107);
    check("t3_ovf_clear", 32'(ovf0), 0);
    goto(113); req0 = 4'b0100; push0(114, 2); push0(126, 2);
    goto(114); req0 = '0;
    at_neg(114);
    check("t3_ovf_grant", 32'(ovf0), 0);
    check("t3_pend_requeue", 32'(pend0), 4'b0100);
    at_neg(126);
    check("t3_pend_drained", 32'(pend0), 0);

    // Test 4: USE_ACK=1 -- early ack, ignored ack in strobe cycle, late ack
    goto(140); req1 = 4'b0011; push1(142, 0);
    goto(141); req1 = '0;
    goto(142); ack1 = 1'b1;
    goto(143); ack1 = 1'b0;
    goto(148); ack1 = 1'b1; push1(154, 1);
    goto(149); ack1 = 1'b0;
    goto(154); ack1 = 1'b1;
    goto(155); ack1 = 1'b0;
    goto(156); req1 = 4'b0100; push1(170, 2);
    goto(157); req1 = '0;
    at_neg(167);
    check("t4_busy_wait_ack", 32'(busy1), 1);
    goto(168); ack1 = 1'b1;
    goto(169); ack1 = 1'b0;
    goto(175); ack1 = 1'b1;
    goto(176); ack1 = 1'b0;
    at_neg(181);
    check("t4_busy_last", 32'(busy1), 1);
    at_neg(182);
    check("t4_busy_idle", 32'(busy1), 0);
    goto(184); req1 = 4'b0001; push1(186, 0);
    goto(185); req1 = '0;
    goto(190); req1 = 4'b0001;
    goto(191); req1 = '0;
    goto(192); req1 = 4'b0001;
    goto(193); req1 = '0;
    at_neg(193);
    check("t4_ovf_noack", 32'(ovf1), 4'b0001);
    at_neg(210);
    check("t4_busy_stuck", 32'(busy1), 1);
    check("t4_pend_stuck", 32'(pend1), 4'b0001);

    // Test 5: reset mid-HOLD with three events pending
    goto(220); req0 = 4'b1000; push0(222, 3);
    goto(221); req0 = '0;
    goto(224); req0 = 4'b0111;
    goto(225); req0 = '0;
    at_neg(226);
    check("t5_pend_pre", 32'(pend0), 4'b0111);
    check("t5_busy_pre", 32'(busy0), 1);
    goto(227); rst_n = 1'b0;
    goto(228); rst_n = 1'b1;
    at_neg(228);
    check("t5_stb0", 32'(stb0), 0);
    check("t5_id0", 32'(id0), 0);
    check("t5_pend0", 32'(pend0), 0);
    check("t5_ovf0", 32'(ovf0), 0);
    check("t5_busy0", 32'(busy0), 0);
    check("t5_pend1", 32'(pend1), 0);
    check("t5_busy1", 32'(busy1), 0);
    goto(251); req0 = 4'b0010; push0(253, 1);
    goto(252); req0 = '0;
    goto(270);

    // Final report
    check("q0_drained", 32'(exp_q0.size()), 0);
    check("q1_drained", 32'(exp_q1.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
